oai21_bist_sequencer: RTL and testbench
=======================================

// Module: oai21_bist_sequencer
// PURPOSE
//  Built-in self-test sequencer for one oai21 cell instance (ZN = !((A1|A2)&B)).
//  - Drives all 8 input vectors into the cell and samples ZN after a programmable settle time.
//  - Compares each sample against the expected value and reports pass/fail, error count and first failing vector.
//  - Sits beside the cell under test in library silicon-validation and characterization test structures.
// PARAMETERS
//  SETTLE_CYCLES  2  extra hold cycles per vector before ZN is sampled (>=0)
//  NUM_PASSES     1  full 8-vector sweeps per run (>=1)
//  ERR_CNT_W      4  width of ERR_CNT (>=1)
// PORTS
//  CLK       in   1          clock, rising edge
//  RN        in   1          asynchronous active-low reset
//  START     in   1          begin run; sampled only in IDLE
//  ABORT     in   1          terminate run; sampled only while BUSY
//  ZN        in   1          output of the oai21 cell under test
//  A1        out  1          drive to cell input A1 (registered)
//  A2        out  1          drive to cell input A2 (registered)
//  B         out  1          drive to cell input B (registered)
//  BUSY      out  1          high while a run is in progress
//  DONE      out  1          one-cycle pulse on normal completion
//  PASS      out  1          high after a completed run with zero mismatches
//  ERR_CNT   out  ERR_CNT_W  saturating mismatch count for the current/last run
//  FAIL_VEC  out  3          {A1,A2,B} of first mismatch; valid when ERR_CNT!=0
// BEHAVIOUR
//  Reset (RN low, async): state=IDLE; A1=A2=B=0; BUSY=DONE=PASS=0; ERR_CNT=0; FAIL_VEC=0.
//  Vector encoding: vec[2:0]={A1,A2,B}; expected = !((vec[2]|vec[1])&vec[0]); order 0..7 per pass.
//  States:
//  - IDLE
//    - START=1 and ABORT=0 -> HOLD at next edge.
//    - On entry to HOLD: vec=0; pass=0; settle=0; ERR_CNT=0; FAIL_VEC=0; PASS=0; BUSY=1.
//  - HOLD
//    - Each vector is driven for exactly SETTLE_CYCLES+1 cycles.
//    - ZN is compared on the last edge of the hold. A mismatch is ZN!==expected; X/Z on ZN counts as a mismatch.
//    - On a mismatch: ERR_CNT++ (saturates at 2^ERR_CNT_W-1). FAIL_VEC is captured only if ERR_CNT was 0.
//    - After the compare: vec++. On vec 7->0 wrap: pass++.
//    - When pass reaches NUM_PASSES -> FINISH; A1/A2/B go to 0 at that edge.
//  - FINISH: one cycle with DONE=1, BUSY=0, PASS=(ERR_CNT==0); then IDLE.
//  - ABORT=1 in HOLD -> IDLE at next edge.
//    - That edge performs no compare.
//    - Outputs at that edge: DONE=0; PASS=0; A1=A2=B=0.
//    - ERR_CNT and FAIL_VEC keep their values.
//  Boundary cases:
//  - START while BUSY or in FINISH: ignored.
//  - START and ABORT both high in IDLE: no run starts.
//  - RN asserted mid-run: immediate return to reset values; no DONE.
//  - Latency: START edge to DONE high = NUM_PASSES*8*(SETTLE_CYCLES+1)+1 cycles.
//  - BUSY duration: exactly NUM_PASSES*8*(SETTLE_CYCLES+1) cycles.
//  - PASS and ERR_CNT hold after a run until the next accepted START or reset.
// TESTING
//  1. Good-cell model, defaults: START pulse -> 24 BUSY cycles, DONE at cycle 25, PASS=1, ERR_CNT=0.
//  2. ZN stuck-at-1 (defaults): mismatches on vec 3,5,7 -> ERR_CNT=3, FAIL_VEC=3'b011, PASS=0.
//  3. ERR_CNT_W=2, NUM_PASSES=2, ZN stuck-at-0 -> 10 mismatches -> ERR_CNT=3 (saturated), FAIL_VEC=3'b000.
//  4. SETTLE_CYCLES=0: each vector held 1 cycle, A1/A2/B step 0..7 on consecutive edges, BUSY=8 cycles.
//  5. ABORT at cycle 10 of a run -> IDLE next edge, DONE never pulses, PASS=0, A1=A2=B=0.
//  6. RN low at cycle 5 mid-run -> all outputs 0 immediately; START during BUSY and START+ABORT in IDLE -> ignored.

Source files
------------

// File: rtl/oai21_bist_sequencer.sv
// ============================================================================
// oai21_bist_sequencer
//
// Built-in self-test sequencer for a single oai21 cell (ZN = !((A1|A2)&B)).
// A run sweeps all eight {A1,A2,B} input vectors NUM_PASSES times. Each
// vector is held for SETTLE_CYCLES+1 cycles, and ZN is compared against the
// ideal cell response on the last edge of that hold. The block reports a
// saturating mismatch count, the first failing vector, and a pass flag at the
// end of the run.
//
// Parameters:
//   SETTLE_CYCLES  extra hold cycles per vector before ZN is sampled (>=0)
//   NUM_PASSES     number of full 8-vector sweeps per run (>=1)
//   ERR_CNT_W      width of ERR_CNT (>=1)
//
// Ports:
//   CLK       in   clock, rising edge
//   RN        in   asynchronous active-low reset
//   START     in   begin a run (only looked at while idle)
//   ABORT     in   terminate a run (only looked at while busy)
//   ZN        in   output of the oai21 cell under test
//   A1,A2,B   out  registered drives to the cell inputs
//   BUSY      out  high while a run is in progress
//   DONE      out  one-cycle pulse on normal completion
//   PASS      out  high after a completed run with zero mismatches
//   ERR_CNT   out  saturating mismatch count for the current/last run
//   FAIL_VEC  out  {A1,A2,B} of the first mismatch, valid when ERR_CNT!=0
// ============================================================================
module oai21_bist_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_CNT_W     = 4
) (
    input  logic                 CLK,
    input  logic                 RN,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic                 ZN,
    output logic                 A1,
    output logic                 A2,
    output logic                 B,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 PASS,
    output logic [ERR_CNT_W-1:0] ERR_CNT,
    output logic [2:0]           FAIL_VEC
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    // Counter widths are forced to at least one bit so that the degenerate
    // SETTLE_CYCLES=0 / NUM_PASSES=1 configurations still elaborate cleanly.
    localparam int SETTLE_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int PASS_W   = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

    localparam logic [SETTLE_W-1:0]  SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES);
    localparam logic [PASS_W-1:0]    PASS_LAST   = PASS_W'(NUM_PASSES - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX     = '1;
    localparam logic [ERR_CNT_W-1:0] ERR_ONE     = ERR_CNT_W'(1);

    logic [1:0]           state;
    logic [2:0]           vec;
    logic [SETTLE_W-1:0]  settle_cnt;
    logic [PASS_W-1:0]    pass_cnt;

    logic                 expected_zn;
    logic                 mismatch;
    logic                 hold_last;
    logic                 sweep_last;
    logic                 start_accept;
    logic                 abort_take;
    logic                 compare_now;
    logic                 run_end;
    logic [ERR_CNT_W-1:0] err_next;

    // Run-control events. ABORT has priority over the compare that would
    // otherwise happen on the same edge, so an aborted edge never scores.
    always_comb begin
        expected_zn  = ~((vec[2] | vec[1]) & vec[0]);
        // Case inequality so an X or Z on ZN is scored as a mismatch in
        // simulation; in silicon this is an ordinary XOR.
        mismatch     = (ZN !== expected_zn);
        hold_last    = (settle_cnt == SETTLE_LAST);
        sweep_last   = (vec == 3'd7) && (pass_cnt == PASS_LAST);
        start_accept = (state == ST_IDLE) && START && !ABORT;
        abort_take   = (state == ST_HOLD) && ABORT;
        compare_now  = (state == ST_HOLD) && !ABORT && hold_last;
        run_end      = compare_now && sweep_last;
    end

    // Saturating increment of the mismatch count for the current compare.
    always_comb begin
        err_next = ERR_CNT;
        if (compare_now && mismatch && (ERR_CNT != ERR_MAX)) begin
            err_next = ERR_CNT + ERR_ONE;
        end
    end

    // Top-level sequencing: IDLE -> HOLD for the whole sweep -> FINISH for
    // the single DONE cycle -> IDLE. START is ignored outside IDLE.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_accept) begin
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (abort_take) begin
                        state <= ST_IDLE;
                    end else if (run_end) begin
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Vector, settle and pass counters. The settle counter runs 0..SETTLE_CYCLES
    // for each vector; the vector advances on the compare edge and the pass
    // counter advances when the vector wraps from 7 back to 0.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            vec        <= 3'd0;
            settle_cnt <= '0;
            pass_cnt   <= '0;
        end else if (start_accept) begin
            vec        <= 3'd0;
            settle_cnt <= '0;
            pass_cnt   <= '0;
        end else if (state == ST_HOLD && !ABORT) begin
            if (!hold_last) begin
                settle_cnt <= settle_cnt + SETTLE_W'(1);
            end else begin
                settle_cnt <= '0;
                vec        <= vec + 3'd1;
                if (vec == 3'd7) begin
                    pass_cnt <= pass_cnt + PASS_W'(1);
                end
            end
        end
    end

    // Mismatch bookkeeping. Only the first failing vector of a run is kept,
    // which is identified by the count still being zero before this compare.
    // Both values survive an abort and a normal finish until the next run.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            ERR_CNT  <= '0;
            FAIL_VEC <= 3'd0;
        end else if (start_accept) begin
            ERR_CNT  <= '0;
            FAIL_VEC <= 3'd0;
        end else if (compare_now) begin
            ERR_CNT <= err_next;
            if (mismatch && (ERR_CNT == '0)) begin
                FAIL_VEC <= vec;
            end
        end
    end

    // Registered drives to the cell. During a sweep the drive always tracks
    // the vector being held; it is parked at zero outside a run so the cell
    // sits in a known state between tests.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            {A1, A2, B} <= 3'b000;
        end else if (start_accept) begin
            {A1, A2, B} <= 3'b000;
        end else if (abort_take || run_end) begin
            {A1, A2, B} <= 3'b000;
        end else if (compare_now) begin
            {A1, A2, B} <= vec + 3'd1;
        end
    end

    // Status flags. PASS is computed from the count including the final
    // compare, so a mismatch on the very last vector still clears it.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            BUSY <= 1'b0;
            DONE <= 1'b0;
            PASS <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (start_accept) begin
                BUSY <= 1'b1;
                PASS <= 1'b0;
            end else if (abort_take) begin
                BUSY <= 1'b0;
                PASS <= 1'b0;
            end else if (run_end) begin
                BUSY <= 1'b0;
                DONE <= 1'b1;
                PASS <= (err_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_oai21_bist_sequencer.sv
// ============================================================================
// tb_oai21_bist_sequencer
//
// Self-checking bench for oai21_bist_sequencer. Three instances share one
// clock and reset: the default configuration, a two-pass 2-bit-counter
// configuration, and a zero-settle configuration. Each instance sees a
// behavioural oai21 cell whose output can be forced to a stuck-at fault.
// ============================================================================
module tb_oai21_bist_sequencer;

    localparam logic [1:0] CELL_GOOD = 2'd0;
    localparam logic [1:0] CELL_SA1  = 2'd1;
    localparam logic [1:0] CELL_SA0  = 2'd2;

    typedef struct {
        logic [1:0] fault;
        int         abort_at;
        int         start_again_at;
        int         exp_busy;
        int         exp_done_cyc;
        logic       exp_pass;
        logic [3:0] exp_err;
        logic [2:0] exp_fail_vec;
    } run_t;

    logic clk;
    logic rst_n;

    int checks;
    int failures;

    // Default instance (SETTLE_CYCLES=2, NUM_PASSES=1, ERR_CNT_W=4)
    logic       start0, abort0, zn0;
    logic [1:0] fault0;
    logic [2:0] drv0;
    logic       busy0, done0, pass0;
    logic [3:0] err0;
    logic [2:0] fv0;

    // Two passes with a 2-bit saturating counter
    logic       start1, abort1, zn1;
    logic [1:0] fault1;
    logic [2:0] drv1;
    logic       busy1, done1, pass1;
    logic [1:0] err1;
    logic [2:0] fv1;

    // No extra settle cycles
    logic       start2, abort2, zn2;
    logic [1:0] fault2;
    logic [2:0] drv2;
    logic       busy2, done2, pass2;
    logic [3:0] err2;
    logic [2:0] fv2;

    // Behavioural cells under test
    assign zn0 = (fault0 == CELL_SA1) ? 1'b1 : (fault0 == CELL_SA0) ? 1'b0
               : ~((drv0[2] | drv0[1]) & drv0[0]);
    assign zn1 = (fault1 == CELL_SA1) ? 1'b1 : (fault1 == CELL_SA0) ? 1'b0
               : ~((drv1[2] | drv1[1]) & drv1[0]);
    assign zn2 = (fault2 == CELL_SA1) ? 1'b1 : (fault2 == CELL_SA0) ? 1'b0
               : ~((drv2[2] | drv2[1]) & drv2[0]);

    oai21_bist_sequencer dut0 (
        .CLK(clk), .RN(rst_n), .START(start0), .ABORT(abort0), .ZN(zn0),
        .A1(drv0[2]), .A2(drv0[1]), .B(drv0[0]),
        .BUSY(busy0), .DONE(done0), .PASS(pass0),
        .ERR_CNT(err0), .FAIL_VEC(fv0)
    );

    oai21_bist_sequencer #(
        .SETTLE_CYCLES(2), .NUM_PASSES(2), .ERR_CNT_W(2)
    ) dut1 (
        .CLK(clk), .RN(rst_n), .START(start1), .ABORT(abort1), .ZN(zn1),
        .A1(drv1[2]), .A2(drv1[1]), .B(drv1[0]),
        .BUSY(busy1), .DONE(done1), .PASS(pass1),
        .ERR_CNT(err1), .FAIL_VEC(fv1)
    );

    oai21_bist_sequencer #(
        .SETTLE_CYCLES(0), .NUM_PASSES(1), .ERR_CNT_W(4)
    ) dut2 (
        .CLK(clk), .RN(rst_n), .START(start2), .ABORT(abort2), .ZN(zn2),
        .A1(drv2[2]), .A2(drv2[1]), .B(drv2[0]),
        .BUSY(busy2), .DONE(done2), .PASS(pass2),
        .ERR_CNT(err2), .FAIL_VEC(fv2)
    );

    // 10 ns clock; stimulus changes and sampling both happen on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full run on the default instance, with optional ABORT and a second
    // START pulse on chosen cycles. Cycle 1 is the first cycle after the
    // edge that accepts START.
    task automatic applyStimulus(input run_t r, input int idx);
        int busy_cnt;
        int done_cyc;
        fault0 = r.fault;
        @(negedge clk);
        start0 = 1'b1;
        busy_cnt = 0;
        done_cyc = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start0 = (cyc == r.start_again_at);
            abort0 = (cyc == r.abort_at);
            if (busy0) busy_cnt++;
            if (done0 && done_cyc == 0) done_cyc = cyc;
        end
        start0 = 1'b0;
        abort0 = 1'b0;
        checkOutput($sformatf("run%0d busy_cycles", idx), busy_cnt, r.exp_busy);
        checkOutput($sformatf("run%0d done_cycle", idx), done_cyc, r.exp_done_cyc);
        checkOutput($sformatf("run%0d pass", idx), pass0, r.exp_pass);
        checkOutput($sformatf("run%0d err_cnt", idx), err0, r.exp_err);
        checkOutput($sformatf("run%0d fail_vec", idx), fv0, r.exp_fail_vec);
        checkOutput($sformatf("run%0d drive_idle", idx), drv0, 3'b000);
        checkOutput($sformatf("run%0d busy_idle", idx), busy0, 1'b0);
    endtask

    initial begin
        run_t runs[6];
        logic [2:0] step_tab[8];
        int busy_cnt;
        int done_cyc;

        checks   = 0;
        failures = 0;
        rst_n  = 1'b0;
        start0 = 1'b0; abort0 = 1'b0; fault0 = CELL_GOOD;
        start1 = 1'b0; abort1 = 1'b0; fault1 = CELL_GOOD;
        start2 = 1'b0; abort2 = 1'b0; fault2 = CELL_GOOD;

        //            fault      abort start2 busy done pass err fail_vec
        runs[0] = '{CELL_GOOD,  0,    0,     24,  25,  1'b1, 4'd0, 3'b000};
        runs[1] = '{CELL_SA1,   0,    0,     24,  25,  1'b0, 4'd3, 3'b011};
        runs[2] = '{CELL_SA0,   0,    0,     24,  25,  1'b0, 4'd5, 3'b000};
        runs[3] = '{CELL_SA0,   10,   0,     10,  0,   1'b0, 4'd3, 3'b000};
        runs[4] = '{CELL_GOOD,  0,    5,     24,  25,  1'b1, 4'd0, 3'b000};
        runs[5] = '{CELL_GOOD,  0,    25,    24,  25,  1'b1, 4'd0, 3'b000};

        step_tab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("reset drive", drv0, 3'b000);
        checkOutput("reset busy", busy0, 1'b0);
        checkOutput("reset done", done0, 1'b0);
        checkOutput("reset pass", pass0, 1'b0);
        checkOutput("reset err_cnt", err0, 4'd0);
        checkOutput("reset fail_vec", fv0, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);

        // Table of full runs on the default instance
        for (int i = 0; i < 6; i++) begin
            applyStimulus(runs[i], i);
        end

        // START together with ABORT while idle must not launch a run
        start0 = 1'b1;
        abort0 = 1'b1;
        busy_cnt = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (busy0) busy_cnt++;
        end
        start0 = 1'b0;
        abort0 = 1'b0;
        checkOutput("start_abort busy_cycles", busy_cnt, 0);
        checkOutput("start_abort pass_held", pass0, 1'b1);

        // Zero settle: vectors step 0..7 on consecutive edges
        @(negedge clk);
        start2 = 1'b1;
        busy_cnt = 0;
        done_cyc = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (busy2) busy_cnt++;
            if (done2 && done_cyc == 0) done_cyc = cyc;
            if (cyc <= 8) begin
                checkOutput($sformatf("settle0 vec cycle%0d", cyc), drv2, step_tab[cyc-1]);
            end
        end
        checkOutput("settle0 busy_cycles", busy_cnt, 8);
        checkOutput("settle0 done_cycle", done_cyc, 9);
        checkOutput("settle0 pass", pass2, 1'b1);
        checkOutput("settle0 drive_idle", drv2, 3'b000);

        // Two passes, stuck-at-0: ten mismatches saturate a 2-bit counter
        fault1 = CELL_SA0;
        @(negedge clk);
        start1 = 1'b1;
        busy_cnt = 0;
        done_cyc = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (busy1) busy_cnt++;
            if (done1 && done_cyc == 0) done_cyc = cyc;
        end
        checkOutput("twopass busy_cycles", busy_cnt, 48);
        checkOutput("twopass done_cycle", done_cyc, 49);
        checkOutput("twopass err_cnt", err1, 2'd3);
        checkOutput("twopass fail_vec", fv1, 3'b000);
        checkOutput("twopass pass", pass1, 1'b0);

        // Reset in the middle of a run on the default instance
        fault0 = CELL_SA0;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("midrun err_before", err0, 4'd1);
        checkOutput("midrun drive_before", drv0, 3'b001);
        rst_n = 1'b0;
        #1;
        checkOutput("midrun reset drive", drv0, 3'b000);
        checkOutput("midrun reset busy", busy0, 1'b0);
        checkOutput("midrun reset err_cnt", err0, 4'd0);
        checkOutput("midrun reset pass", pass0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        busy_cnt = 0;
        done_cyc = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (busy0) busy_cnt++;
            if (done0 && done_cyc == 0) done_cyc = cyc;
        end
        checkOutput("midrun no_busy", busy_cnt, 0);
        checkOutput("midrun no_done", done_cyc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
